handshake4_rx: RTL and testbench

- Destination-side receiver of a 4-phase req/ack level handshake crossing into clk_dest.
- Consumes the synchronized request level produced by the upstream two-flop level synchronizer and captures the quasi-static source data bus into a one-entry output buffer.
- Produces the ack level, which returns to the source domain through another level synchronizer.
- Presents captured words to local logic with a valid/ready interface; flags a stuck request with a timeout.

---
 rtl/handshake4_rx.sv | 97 +++++++++
 tb/tb_handshake4_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/handshake4_rx.sv
// handshake4_rx: destination side of a 4-phase req/ack level handshake.
// Captures the quasi-static source word into a one-entry buffer, returns the
// ack level, and presents the word to local logic via valid/ready.
// A request held high too long after ack raises a sticky timeout flag.
module handshake4_rx #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk_dest,
  input  logic                  rst_dest_n,
  input  logic                  req_sync,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  ack,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  err_timeout,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  // Timeout counter just wide enough to hold TIMEOUT_CYCLES (min 1 bit).
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, WAIT_REQ_LO} state_t;

  state_t                state_q;
  logic                  ack_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [TW-1:0]         tmo_q;

  logic                  buf_free;
  logic [TW-1:0]         tmo_d;

  assign buf_free = !valid_q || out_ready;
  // Saturating increment: once at TMAX the counter parks there, so the
  // timeout keeps re-asserting while req stays high (set beats clear).
  assign tmo_d    = (tmo_q == TMAX) ? tmo_q : tmo_q + TW'(1);

  // Handshake FSM with registered outputs, buffer, counters and error flag.
  always_ff @(posedge clk_dest or negedge rst_dest_n) begin
    if (!rst_dest_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      // Clear and pop first; a same-cycle set/capture below overrides them.
      if (err_clr) err_q <= 1'b0;
      if (valid_q && out_ready) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Backpressure: with the buffer occupied ack stays low and the
          // source simply keeps waiting.
          if (req_sync && buf_free) begin
            data_q  <= src_data;
            valid_q <= 1'b1;
            ack_q   <= 1'b1;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
            tmo_q   <= '0;
            state_q <= WAIT_REQ_LO;
          end
        end
        WAIT_REQ_LO: begin
          // Only a low req returns to IDLE, so each req phase captures once.
          if (!req_sync) begin
            ack_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_d;
            if (TIMEOUT_CYCLES != 0 && tmo_d == TMAX) err_q <= 1'b1;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign err_timeout = err_q;
  assign xfer_count  = cnt_q;

endmodule

// File: tb/tb_handshake4_rx.sv
// Directed + table-driven + randomized bench for handshake4_rx.
module tb_handshake4_rx;

  logic        clk_dest = 1'b0;
  logic        rst_dest_n;
  logic        req_sync;
  logic [31:0] src_data;
  logic        ack;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        err_timeout;
  logic        err_clr;
  logic [3:0]  xfer_count;

  int checks   = 0;
  int failures = 0;

  handshake4_rx #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut (
    .clk_dest(clk_dest), .rst_dest_n(rst_dest_n), .req_sync(req_sync),
    .src_data(src_data), .ack(ack), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .err_timeout(err_timeout), .err_clr(err_clr),
    .xfer_count(xfer_count)
  );

  always #5 clk_dest = ~clk_dest;

  typedef struct {
    logic        req;
    logic        rdy;
    logic [31:0] data;
    logic        ack;
    logic        vld;
    logic [31:0] odata;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(posedge clk_dest);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_dest_n = 1'b0;
    tick();
    rst_dest_n = 1'b1;
    tick();
  endtask

  logic [31:0] sbq[$];
  logic        req_src, r1, ack1, ack2;
  int          sent, rcvd;

  initial begin
    rst_dest_n = 1'b0;
    req_sync   = 1'b0;
    src_data   = '0;
    out_ready  = 1'b0;
    err_clr    = 1'b0;

    //            req rdy data          ack vld odata         cnt
    vt[0]  = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        4'd0};
    vt[1]  = '{1'b1, 1'b1, 32'hA5A50001, 1'b1, 1'b1, 32'hA5A50001, 4'd1};
    vt[2]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hA5A50001, 4'd1};
    vt[3]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hA5A50001, 4'd1};
    vt[4]  = '{1'b1, 1'b0, 32'h11112222, 1'b1, 1'b1, 32'h11112222, 4'd2};
    vt[5]  = '{1'b0, 1'b0, 32'h11112222, 1'b0, 1'b1, 32'h11112222, 4'd2};
    vt[6]  = '{1'b1, 1'b0, 32'h33334444, 1'b0, 1'b1, 32'h11112222, 4'd2};
    vt[7]  = '{1'b1, 1'b0, 32'h33334444, 1'b0, 1'b1, 32'h11112222, 4'd2};
    vt[8]  = '{1'b1, 1'b1, 32'h33334444, 1'b1, 1'b1, 32'h33334444, 4'd3};
    vt[9]  = '{1'b0, 1'b0, 32'h33334444, 1'b0, 1'b1, 32'h33334444, 4'd3};
    vt[10] = '{1'b0, 1'b1, 32'h33334444, 1'b0, 1'b0, 32'h33334444, 4'd3};

    // Reset state.
    tick(); tick();
    rst_dest_n = 1'b1;
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_cnt", 32'(xfer_count), 32'd0);

    // Basic capture, backpressure and simultaneous pop+capture.
    for (int i = 0; i < 11; i++) begin
      req_sync = vt[i].req; out_ready = vt[i].rdy; src_data = vt[i].data;
      tick();
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vt[i].ack));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d_data", i), out_data, vt[i].odata);
      chk($sformatf("vec%0d_cnt", i), 32'(xfer_count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_err", i), 32'(err_timeout), 32'd0);
    end

    // Timeout: err sets exactly 8 cycles after entering WAIT_REQ_LO.
    req_sync = 1'b1; out_ready = 1'b1; src_data = 32'hBEEF0005;
    tick();
    chk("tmo_capture_ack", 32'(ack), 32'd1);
    chk("tmo_capture_cnt", 32'(xfer_count), 32'd4);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("tmo_err_c%0d", k), 32'(err_timeout), (k == 8) ? 32'd1 : 32'd0);
    end
    chk("tmo_ack_held", 32'(ack), 32'd1);
    err_clr = 1'b1;
    tick();
    chk("tmo_set_wins", 32'(err_timeout), 32'd1);
    err_clr = 1'b0; req_sync = 1'b0;
    tick();
    chk("tmo_release_ack", 32'(ack), 32'd0);
    chk("tmo_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    chk("tmo_cleared", 32'(err_timeout), 32'd0);
    err_clr = 1'b0;

    // Reset mid-transfer takes effect immediately (async).
    out_ready = 1'b0; req_sync = 1'b1; src_data = 32'hC0DE0006;
    tick();
    chk("mid_ack", 32'(ack), 32'd1);
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_cnt", 32'(xfer_count), 32'd5);
    #2 rst_dest_n = 1'b0;
    #1;
    chk("async_ack", 32'(ack), 32'd0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_cnt", 32'(xfer_count), 32'd0);
    chk("async_data", out_data, 32'd0);
    req_sync = 1'b0; out_ready = 1'b1;
    tick();
    rst_dest_n = 1'b1;
    tick();
    req_sync = 1'b1; src_data = 32'h12345678;
    tick();
    chk("post_rst_ack", 32'(ack), 32'd1);
    chk("post_rst_data", out_data, 32'h12345678);
    chk("post_rst_cnt", 32'(xfer_count), 32'd1);
    req_sync = 1'b0;
    tick();
    chk("post_rst_rel", 32'(ack), 32'd0);

    // Counter wrap: 17 handshakes with a 4-bit counter ends at 1.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      req_sync = 1'b1; src_data = 32'h1000 + 32'(i);
      tick();
      chk($sformatf("wrap%0d_data", i), out_data, 32'h1000 + 32'(i));
      src_data = 32'hDEAD0000;
      tick();
      chk($sformatf("wrap%0d_nodup", i), 32'(xfer_count), 32'((i + 1) % 16));
      req_sync = 1'b0;
      tick();
      chk($sformatf("wrap%0d_rel", i), 32'(ack), 32'd0);
    end
    chk("wrap_final_cnt", 32'(xfer_count), 32'd1);

    // Randomized: source FSM through model 2-flop synchronizers both ways.
    do_reset();
    req_src = 1'b0; r1 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
    sent = 0; rcvd = 0;
    for (int c = 0; c < 4000 && rcvd < 30; c++) begin
      req_sync = r1; r1 = req_src;
      ack2 = ack1; ack1 = ack;
      if (!req_src && !ack2 && sent < 30 && $urandom_range(0, 2) == 0) begin
        src_data = $urandom;
        sbq.push_back(src_data);
        req_src = 1'b1;
        sent++;
      end else if (req_src && ack2) begin
        req_src = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("rand_unexpected_word", out_data, 32'hxxxxxxxx);
        end else begin
          chk($sformatf("rand_word%0d", rcvd), out_data, sbq.pop_front());
        end
        rcvd++;
      end
      tick();
    end
    chk("rand_received", 32'(rcvd), 32'd30);
    chk("rand_queue_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
